// File: rtl/seg7_pkg.sv
// Shared constants and the hex-to-segment table for the
// multiplexed seven-segment scan controller.
package seg7_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    // Active-low g..a patterns, entry n at HEX_SEG[n]
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble + decimal point to active-low
// segment pattern {dp, g..a}.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {~dp, HEX_SEG[nibble]};

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with frame-aligned
// double-buffered loads, PWM brightness and digit blinking.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int DIV          = 8000,
    parameter int BRIGHT_W     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] din,
    input  logic [N_DIGITS-1:0]   dp,
    input  logic [N_DIGITS-1:0]   blank,
    input  logic [N_DIGITS-1:0]   blink,
    input  logic [BRIGHT_W-1:0]   bright,
    input  logic                  load,
    output logic                  busy,
    output logic                  frame_start,
    output logic [N_DIGITS-1:0]   AN,
    output logic [7:0]            SEG
);

    localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int PW = QW + BRIGHT_W + 1;

    logic [QW-1:0] q;
    logic [CW-1:0] cntr;
    logic [FW-1:0] fcnt;
    logic          phase;
    logic          en;
    logic          last;
    logic          fb;

    logic [4*N_DIGITS-1:0] s_din;
    logic [N_DIGITS-1:0]   s_dp;
    logic [N_DIGITS-1:0]   s_blank;
    logic [N_DIGITS-1:0]   s_blink;
    logic [BRIGHT_W-1:0]   s_bright;

    logic [4*N_DIGITS-1:0] a_din;
    logic [N_DIGITS-1:0]   a_dp;
    logic [N_DIGITS-1:0]   a_blank;
    logic [N_DIGITS-1:0]   a_blink;
    logic [BRIGHT_W-1:0]   a_bright;

    logic [3:0]          nib;
    logic                dp_sel;
    logic                blank_sel;
    logic                blink_sel;
    logic [N_DIGITS-1:0] an_sel;
    logic [PW-1:0]       t_on;
    logic                dark;
    logic [7:0]          seg_lit;

    assign en   = (q == QW'(DIV - 1));
    assign last = (cntr == CW'(N_DIGITS - 1));
    assign fb   = en && last;

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            cntr <= '0;
        end else begin
            q <= en ? '0 : q + QW'(1);
            if (en)
                cntr <= last ? '0 : cntr + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (fb) begin
            if (fcnt == FW'(BLINK_FRAMES - 1)) begin
                fcnt  <= '0;
                phase <= ~phase;
            end else begin
                fcnt <= fcnt + FW'(1);
            end
        end
    end

    // A load on the boundary cycle still lands in staging and stays pending
    always_ff @(posedge clk) begin
        if (rst) begin
            s_din    <= '0;
            s_dp     <= '0;
            s_blank  <= '1;
            s_blink  <= '0;
            s_bright <= '1;
            busy     <= 1'b0;
        end else begin
            if (load) begin
                s_din    <= din;
                s_dp     <= dp;
                s_blank  <= blank;
                s_blink  <= blink;
                s_bright <= bright;
            end
            if (load)
                busy <= 1'b1;
            else if (fb)
                busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_din    <= '0;
            a_dp     <= '0;
            a_blank  <= '1;
            a_blink  <= '0;
            a_bright <= '1;
        end else if (fb && busy) begin
            a_din    <= s_din;
            a_dp     <= s_dp;
            a_blank  <= s_blank;
            a_blink  <= s_blink;
            a_bright <= s_bright;
        end
    end

    always_comb begin
        nib       = '0;
        dp_sel    = 1'b0;
        blank_sel = 1'b1;
        blink_sel = 1'b0;
        an_sel    = AN_OFF[N_DIGITS-1:0];
        for (int k = 0; k < N_DIGITS; k++) begin
            if (cntr == CW'(k)) begin
                nib       = a_din[4*k +: 4];
                dp_sel    = a_dp[k];
                blank_sel = a_blank[k];
                blink_sel = a_blink[k];
                an_sel[k] = 1'b0;
            end
        end
    end

    assign t_on = ((PW'(a_bright) + PW'(1)) * PW'(DIV)) >> BRIGHT_W;

    assign dark = blank_sel
               || (phase && blink_sel)
               || !(PW'(q) < t_on);

    seg7_decode u_dec (
        .nibble (nib),
        .dp     (dp_sel),
        .seg    (seg_lit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            AN          <= AN_OFF[N_DIGITS-1:0];
            SEG         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            AN          <= dark ? AN_OFF[N_DIGITS-1:0] : an_sel;
            SEG         <= dark ? SEG_OFF : seg_lit;
            frame_start <= (q == '0) && (cntr == '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: per-frame expectations are queued by the
// stimulus and checked by a frame monitor on the pins.
module tb_seg7_scan_ctrl;

    typedef struct packed {
        int              id;
        logic [3:0][4:0] lit;
        logic [3:0][7:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic [3:0]  blink = '0;
    logic [1:0]  bright = '0;
    logic        load = 1'b0;
    logic        busy;
    logic        frame_start;
    logic [3:0]  AN;
    logic [7:0]  SEG;

    always #5 clk = ~clk;

    seg7_scan_ctrl #(
        .N_DIGITS     (4),
        .DIV          (16),
        .BRIGHT_W     (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .dp          (dp),
        .blank       (blank),
        .blink       (blink),
        .bright      (bright),
        .load        (load),
        .busy        (busy),
        .frame_start (frame_start),
        .AN          (AN),
        .SEG         (SEG)
    );

    logic [6:0] hexs [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int   total = 0;
    int   bad = 0;
    int   fnum = 0;
    int   base = 0;
    exp_t q_exp[$];

    logic [15:0] sh_din, pd_din;
    logic [3:0]  sh_dp, sh_blank, sh_blink, pd_dp, pd_blank, pd_blink;
    logic [1:0]  sh_bright, pd_bright;
    bit          pend = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endfunction

    // Frame monitor: accumulates 64 output cycles from each frame_start
    bit              inframe = 0;
    int              cyc = 0;
    int              cur_id = 0;
    int              slot;
    bit              glitch;
    logic [3:0][4:0] m_lit;
    logic [3:0][7:0] m_seg;

    task automatic finish_frame();
        exp_t e;
        while (q_exp.size() > 0 && q_exp[0].id < cur_id) begin
            e = q_exp.pop_front();
            chk($sformatf("frame%0d_missed", e.id), 1, 0);
        end
        if (q_exp.size() > 0 && q_exp[0].id == cur_id) begin
            e = q_exp.pop_front();
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("f%0d_lit%0d", cur_id, k), 32'(m_lit[k]), 32'(e.lit[k]));
                if (e.lit[k] != 0)
                    chk($sformatf("f%0d_seg%0d", cur_id, k), 32'(m_seg[k]), 32'(e.seg[k]));
            end
            chk($sformatf("f%0d_glitch", cur_id), 32'(glitch), 0);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            inframe = 0;
        end else begin
            if (frame_start) begin
                if (inframe)
                    chk("frame_start_early", cyc, 64);
                fnum++;
                cur_id  = fnum;
                inframe = 1;
                cyc     = 0;
                m_lit   = '0;
                m_seg   = {4{8'hFF}};
                glitch  = 0;
            end
            if (inframe) begin
                slot = cyc / 16;
                if (AN != 4'hF) begin
                    if (AN != ~(4'b0001 << slot)) begin
                        glitch = 1;
                    end else begin
                        m_lit[slot] = m_lit[slot] + 5'd1;
                        m_seg[slot] = SEG;
                    end
                end else if (SEG != 8'hFF) begin
                    glitch = 1;
                end
                cyc++;
                if (cyc == 64) begin
                    inframe = 0;
                    finish_frame();
                end
            end
        end
    end

    function automatic exp_t mk(int id);
        exp_t e;
        int   ph;
        bit   dk;
        ph   = ((id - base) / 2) % 2;
        e.id = id;
        for (int k = 0; k < 4; k++) begin
            dk = sh_blank[k] || (ph == 1 && sh_blink[k]);
            e.lit[k] = dk ? 5'd0 : 5'(4 * (int'(sh_bright) + 1));
            e.seg[k] = {~sh_dp[k], hexs[sh_din[4*k +: 4]]};
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(output int id, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < 300);
        if (!frame_start)
            chk("frame_start_timeout", 0, 1);
        id = fnum + 1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] bl, input logic [3:0] bk,
                           input logic [1:0] br);
        din = d; dp = p; blank = bl; blink = bk; bright = br;
        load = 1'b1;
        tick();
        load = 1'b0;
        pd_din = d; pd_dp = p; pd_blank = bl; pd_blink = bk; pd_bright = br;
        pend = 1;
    endtask

    task automatic apply_pending();
        if (pend) begin
            sh_din = pd_din; sh_dp = pd_dp; sh_blank = pd_blank;
            sh_blink = pd_blink; sh_bright = pd_bright;
            pend = 0;
        end
    endtask

    task automatic reset_model();
        sh_din = '0; sh_dp = '0; sh_blank = '1; sh_blink = '0; sh_bright = '1;
        pend = 0;
    endtask

    initial begin
        int id, n;
        reset_model();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_an", 32'(AN), 32'hF);
        chk("rst_seg", 32'(SEG), 32'hFF);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fs", 32'(frame_start), 0);
        rst = 1'b0;

        wait_fs(id, n);
        base = id;
        q_exp.push_back(mk(id));
        wait_fs(id, n);
        chk("fs_interval1", n, 64);
        q_exp.push_back(mk(id));
        wait_fs(id, n);
        chk("fs_interval2", n, 64);
        q_exp.push_back(mk(id));

        repeat (20) tick();
        do_load(16'h3A7F, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        chk("busy_after_load", 32'(busy), 1);
        wait_fs(id, n);
        chk("busy_clear_fb", 32'(busy), 0);
        apply_pending();
        q_exp.push_back(mk(id));

        repeat (20) tick();
        do_load(16'h3A7F, 4'b0001, 4'b0000, 4'b0000, 2'd0);
        wait_fs(id, n);
        apply_pending();
        q_exp.push_back(mk(id));

        repeat (20) tick();
        do_load(16'h3A7F, 4'b0000, 4'b1000, 4'b0000, 2'd2);
        wait_fs(id, n);
        apply_pending();
        q_exp.push_back(mk(id));

        repeat (5) tick();
        do_load(16'h3A7F, 4'b0000, 4'b0000, 4'b0010, 2'd3);
        wait_fs(id, n);
        apply_pending();
        q_exp.push_back(mk(id));
        for (int f = 0; f < 4; f++) begin
            wait_fs(id, n);
            q_exp.push_back(mk(id));
        end

        repeat (10) tick();
        do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        chk("busy_multi1", 32'(busy), 1);
        repeat (10) tick();
        do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        repeat (40) tick();
        apply_pending();
        do_load(16'h3333, 4'b0000, 4'b0000, 4'b0000, 2'd3);
        chk("busy_fb_load", 32'(busy), 1);
        wait_fs(id, n);
        chk("fb_load_align", n, 1);
        chk("busy_between", 32'(busy), 1);
        q_exp.push_back(mk(id));
        wait_fs(id, n);
        chk("busy_after_3333", 32'(busy), 0);
        apply_pending();
        q_exp.push_back(mk(id));

        wait_fs(id, n);
        repeat (10) tick();
        do_load(16'h4444, 4'b1111, 4'b0000, 4'b0000, 2'd3);
        chk("busy_pre_rst", 32'(busy), 1);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        reset_model();
        chk("midrst_an", 32'(AN), 32'hF);
        chk("midrst_seg", 32'(SEG), 32'hFF);
        chk("midrst_busy", 32'(busy), 0);
        wait_fs(id, n);
        base = id;
        q_exp.push_back(mk(id));
        wait_fs(id, n);
        chk("busy_post_rst", 32'(busy), 0);
        q_exp.push_back(mk(id));

        n = 0;
        while (q_exp.size() > 0 && n < 200) begin
            tick();
            n++;
        end
        chk("scoreboard_drained", q_exp.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
